zeroheti_sig_dump: RTL and testbench

ZEROHETI_SIG_DUMP -- requirements
Module: zeroheti_sig_dump

---
 rtl/zeroheti_pkg.sv | 21 ++
 rtl/zeroheti_watchdog.sv | 22 ++
 rtl/zeroheti_sig_dump.sv | 156 +++++++++++++++
 tb/tb_zeroheti_sig_dump.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared types and control-window layout for the signature dump block.
// The FSM state enum and window offsets live here so every file agrees on them.
package zeroheti_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_EMIT = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [31:0] SigBeginOfs = 32'h0000_0000;
   localparam logic [31:0] SigEndOfs   = 32'h0000_0004;
   localparam logic [31:0] TohostOfs   = 32'h0000_0008;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/zeroheti_watchdog.sv
// Idle watchdog: counts enabled cycles and flags the cycle the count reaches limit-1.
module zeroheti_watchdog (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [31:0] limit_i,
   output logic        expired_o
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= 32'd0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign expired_o = en_i && (cnt_q == (limit_i - 32'd1));

endmodule

// File: rtl/zeroheti_sig_dump.sv
// Snoops the core's control-window writes, then streams the signature region
// word by word through a single-outstanding OBI read port.
module zeroheti_sig_dump
   import zeroheti_pkg::*;
#(
   parameter logic [31:0] CtrlBase      = 32'h0001_F000,
   parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        snp_req_i,
   input  logic        snp_gnt_i,
   input  logic        snp_we_i,
   input  logic [31:0] snp_addr_i,
   input  logic [31:0] snp_wdata_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic        mem_err_i,
   input  logic [31:0] mem_rdata_i,
   output logic        sig_valid_o,
   output logic [31:0] sig_data_o,
   output logic        sig_last_o,
   input  logic        sig_ready_i,
   output logic        test_done_o,
   output logic        test_pass_o,
   output logic        timeout_o,
   output logic        sig_err_o,
   output logic [30:0] test_code_o
);

   state_e      state_q, state_d;
   logic [31:0] begin_q, begin_d, end_q, end_d, ptr_q, ptr_d, data_q, data_d;
   logic [30:0] code_q, code_d;
   logic        err_q, err_d, timeout_q, timeout_d;
   logic        snp_ev, ev_begin, ev_end, ev_tohost, wd_expired, last_w;

   assign snp_ev    = snp_req_i & snp_gnt_i & snp_we_i;
   assign ev_begin  = snp_ev && (snp_addr_i == (CtrlBase + SigBeginOfs));
   assign ev_end    = snp_ev && (snp_addr_i == (CtrlBase + SigEndOfs));
   assign ev_tohost = snp_ev && (snp_addr_i == (CtrlBase + TohostOfs)) && snp_wdata_i[0];
   assign last_w    = (ptr_q + 32'd4) == end_q;

   zeroheti_watchdog u_watchdog (
      .clk_i     (clk_i),
      .clr_i     (rst_i),
      .en_i      ((state_q == ST_IDLE) && (TimeoutCycles != 32'd0)),
      .limit_i   (TimeoutCycles),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         begin_q   <= 32'd0;
         end_q     <= 32'd0;
         ptr_q     <= 32'd0;
         data_q    <= 32'd0;
         code_q    <= 31'd0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         begin_q   <= begin_d;
         end_q     <= end_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         code_q    <= code_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      begin_d   = begin_q;
      end_d     = end_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      code_d    = code_q;
      err_d     = err_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (ev_begin) begin_d = word_align(snp_wdata_i);
            if (ev_end)   end_d   = word_align(snp_wdata_i);
            // A tohost write in the same cycle as watchdog expiry wins.
            if (ev_tohost) begin
               code_d = snp_wdata_i[31:1];
               ptr_d  = begin_q;
               if (end_q <= begin_q) begin
                  state_d = ST_DONE;
                  err_d   = err_q | (end_q < begin_q);
               end else begin
                  state_d = ST_REQ;
               end
            end else if (wd_expired) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               data_d  = mem_rdata_i;
               err_d   = err_q | mem_err_i;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (sig_ready_i) begin
               ptr_d   = ptr_q + 32'd4;
               state_d = last_w ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o   = 1'b0;
      sig_valid_o = 1'b0;
      sig_last_o  = 1'b0;
      test_done_o = 1'b0;
      test_pass_o = 1'b0;
      case (state_q)
         ST_REQ:  mem_req_o = 1'b1;
         ST_EMIT: begin
            sig_valid_o = 1'b1;
            sig_last_o  = last_w;
         end
         ST_DONE: begin
            test_done_o = 1'b1;
            test_pass_o = (code_q == 31'd0) && !timeout_q;
         end
         default: ;
      endcase
   end

   assign mem_addr_o  = ptr_q;
   assign mem_we_o    = 1'b0;
   assign mem_be_o    = 4'hF;
   assign sig_data_o  = data_q;
   assign sig_err_o   = err_q;
   assign timeout_o   = timeout_q;
   assign test_code_o = code_q;

endmodule

// File: tb/tb_zeroheti_sig_dump.sv
// Directed bench for zeroheti_sig_dump: OBI memory responder, stream scoreboard
// built from the region bounds, and end-of-test status checks.
module tb_zeroheti_sig_dump;
  localparam logic [31:0] CTRL = 32'h0001_F000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        snp_req_i, snp_gnt_i, snp_we_i;
  logic [31:0] snp_addr_i, snp_wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        sig_valid_o, sig_last_o, sig_ready_i;
  logic [31:0] sig_data_o;
  logic        test_done_o, test_pass_o, timeout_o, sig_err_o;
  logic [30:0] test_code_o;

  always #5 clk = ~clk;

  zeroheti_sig_dump #(.CtrlBase(CTRL), .TimeoutCycles(32'd100)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .snp_req_i(snp_req_i), .snp_gnt_i(snp_gnt_i), .snp_we_i(snp_we_i),
    .snp_addr_i(snp_addr_i), .snp_wdata_i(snp_wdata_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o), .sig_last_o(sig_last_o), .sig_ready_i(sig_ready_i),
    .test_done_o(test_done_o), .test_pass_o(test_pass_o), .timeout_o(timeout_o),
    .sig_err_o(sig_err_o), .test_code_o(test_code_o)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem_m [logic [31:0]];

  // responder / stream bookkeeping
  int          gnt_delay = 0, rv_lag = 0, wait_cnt = 0, rv_cnt = 0, ready_mode = 0, cyc = 0, words_seen = 0;
  logic        pend = 1'b0, err_en = 1'b0, prev_stall_req = 1'b0, prev_out_stall = 1'b0;
  logic        saw_req = 1'b0, saw_valid = 1'b0;
  logic [31:0] err_addr = 32'd0, pend_addr = 32'd0, prev_addr = 32'd0, prev_data = 32'd0;
  logic [32:0] pop_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return ~a;
  endfunction

  // Expected stream: one word per address from begin up to (not including) end.
  task automatic build_exp(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] a;
    a = b;
    if (e > b) begin
      while (a != e) begin
        exp_q.push_back({(a + 32'd4) == e, mem_word(a)});
        a = a + 32'd4;
      end
    end
  endtask

  // Memory responder, stream driver and compare process.
  always @(negedge clk) begin
    cyc++;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'd0;
    if (!rst_i) begin
      if (mem_req_o)   saw_req = 1'b1;
      if (sig_valid_o) saw_valid = 1'b1;
      if (pend) check("one_outstanding", mem_req_o, 1'b0);
      if (prev_stall_req) begin
        check("req_held", mem_req_o, 1'b1);
        check("addr_stable", mem_addr_o, prev_addr);
      end
    end
    if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(pend_addr);
        mem_err_i    = err_en && (pend_addr == err_addr);
        pend = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
    mem_gnt_i = 1'b0;
    prev_stall_req = 1'b0;
    if (mem_req_o && !rst_i) begin
      if (wait_cnt >= gnt_delay) begin
        mem_gnt_i = 1'b1;
        pend      = 1'b1;
        pend_addr = mem_addr_o;
        rv_cnt    = rv_lag;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
        prev_stall_req = 1'b1;
        prev_addr = mem_addr_o;
      end
    end
    sig_ready_i = (ready_mode == 0) ? 1'b1 : cyc[0];
    if (!rst_i) begin
      if (prev_out_stall) begin
        check("valid_held", sig_valid_o, 1'b1);
        check("data_stable", sig_data_o, prev_data);
      end
      if (sig_valid_o && sig_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h required no word", sig_data_o);
        end else begin
          pop_e = exp_q.pop_front();
          check("sig_data", sig_data_o, pop_e[31:0]);
          check("sig_last", sig_last_o, pop_e[32]);
          words_seen++;
        end
      end
    end
    prev_out_stall = sig_valid_o && !sig_ready_i && !rst_i;
    prev_data = sig_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic snoop_wr(input logic [31:0] a, input logic [31:0] d);
    tick();
    snp_req_i = 1'b1; snp_gnt_i = 1'b1; snp_we_i = 1'b1; snp_addr_i = a; snp_wdata_i = d;
    tick();
    snp_req_i = 1'b0; snp_gnt_i = 1'b0; snp_we_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    snp_req_i = 1'b0; snp_gnt_i = 1'b0; snp_we_i = 1'b0;
    exp_q.delete();
    mem_m.delete();
    pend = 1'b0; wait_cnt = 0; gnt_delay = 0; rv_lag = 0; ready_mode = 0; err_en = 1'b0;
    saw_req = 1'b0; saw_valid = 1'b0; words_seen = 0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!test_done_o && n < limit) begin
      tick();
      n++;
    end
    if (!test_done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_done_bound: got no test_done_o within %0d cycles, required done", tag, limit);
    end
  endtask

  task automatic check_status(input string tag, input logic pass, input logic [30:0] code,
                              input logic err, input logic tmo);
    check({tag, "_done"}, test_done_o, 1'b1);
    check({tag, "_pass"}, test_pass_o, pass);
    check({tag, "_code"}, test_code_o, code);
    check({tag, "_err"}, sig_err_o, err);
    check({tag, "_timeout"}, timeout_o, tmo);
    check({tag, "_words_left"}, exp_q.size(), 0);
    repeat (3) tick();
    check({tag, "_done_held"}, test_done_o, 1'b1);
    check({tag, "_idle_req"}, mem_req_o, 1'b0);
  endtask

  task automatic load_abcd();
    mem_m[32'h2000] = 32'hA;
    mem_m[32'h2004] = 32'hB;
    mem_m[32'h2008] = 32'hC;
    mem_m[32'h200C] = 32'hD;
  endtask

  initial begin
    int lat;
    int n;
    rst_i = 1'b1; snp_req_i = 1'b0; snp_gnt_i = 1'b0; snp_we_i = 1'b0;
    snp_addr_i = 32'd0; snp_wdata_i = 32'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'd0; sig_ready_i = 1'b1;

    // Reset state
    do_reset();
    check("rst_req", mem_req_o, 1'b0);
    check("rst_valid", sig_valid_o, 1'b0);
    check("rst_done", test_done_o, 1'b0);
    check("rst_data", sig_data_o, 32'd0);
    check("rst_code", test_code_o, 31'd0);
    check("mem_we", mem_we_o, 1'b0);
    check("mem_be", mem_be_o, 4'hF);

    // Basic dump of four words, with ignored snoops first
    load_abcd();
    tick();
    snp_req_i = 1'b1; snp_gnt_i = 1'b0; snp_we_i = 1'b1; snp_addr_i = CTRL + 32'h8; snp_wdata_i = 32'h1;
    tick();
    snp_req_i = 1'b0; snp_we_i = 1'b0;
    snoop_wr(CTRL + 32'h8, 32'h2);
    repeat (2) tick();
    check("ignored_tohost_done", test_done_o, 1'b0);
    check("ignored_tohost_req", saw_req, 1'b0);
    snoop_wr(CTRL + 32'h0, 32'h2000);
    snoop_wr(CTRL + 32'h4, 32'h2012);
    build_exp(32'h2000, 32'h2010);
    check("model_len", exp_q.size(), 4);
    check("model_tail", exp_q[3], {1'b1, 32'hD});
    snoop_wr(CTRL + 32'h8, 32'h1);
    lat = 1;
    while (!sig_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("first_latency", lat, 3);
    wait_done("basic", 100);
    check("basic_words", words_seen, 4);
    check_status("basic", 1'b1, 31'd0, 1'b0, 1'b0);

    // Failing code
    do_reset();
    load_abcd();
    snoop_wr(CTRL + 32'h0, 32'h2000);
    snoop_wr(CTRL + 32'h4, 32'h2010);
    build_exp(32'h2000, 32'h2010);
    snoop_wr(CTRL + 32'h8, 32'h7);
    wait_done("code3", 100);
    check_status("code3", 1'b0, 31'd3, 1'b0, 1'b0);

    // Empty region: done the cycle after the tohost write
    do_reset();
    snoop_wr(CTRL + 32'h0, 32'h3000);
    snoop_wr(CTRL + 32'h4, 32'h3000);
    snoop_wr(CTRL + 32'h8, 32'h1);
    check("empty_done_next", test_done_o, 1'b1);
    check("empty_no_req", saw_req, 1'b0);
    check_status("empty", 1'b1, 31'd0, 1'b0, 1'b0);

    // Reversed region
    do_reset();
    snoop_wr(CTRL + 32'h0, 32'h3000);
    snoop_wr(CTRL + 32'h4, 32'h2FF0);
    snoop_wr(CTRL + 32'h8, 32'h1);
    check("rev_no_req", saw_req, 1'b0);
    check_status("rev", 1'b1, 31'd0, 1'b1, 1'b0);

    // Stalls: slow grant, toggling ready, bus error on word 2, snoop mid-dump
    do_reset();
    load_abcd();
    gnt_delay = 5;
    ready_mode = 1;
    err_en = 1'b1;
    err_addr = 32'h2008;
    snoop_wr(CTRL + 32'h0, 32'h2000);
    snoop_wr(CTRL + 32'h4, 32'h2010);
    build_exp(32'h2000, 32'h2010);
    snoop_wr(CTRL + 32'h8, 32'h1);
    snoop_wr(CTRL + 32'h0, 32'h9000);
    wait_done("stall", 400);
    check("stall_words", words_seen, 4);
    check_status("stall", 1'b1, 31'd0, 1'b1, 1'b0);

    // Watchdog timeout with no tohost write
    do_reset();
    n = 0;
    while (!test_done_o && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycle", n, 100);
    check_status("timeout", 1'b0, 31'd0, 1'b0, 1'b1);

    // Reset during WAIT, response arrives afterwards
    do_reset();
    load_abcd();
    rv_lag = 6;
    snoop_wr(CTRL + 32'h0, 32'h2000);
    snoop_wr(CTRL + 32'h4, 32'h2010);
    snoop_wr(CTRL + 32'h8, 32'h1);
    n = 0;
    while (!pend && n < 20) begin
      tick();
      n++;
    end
    check("wait_reached", pend, 1'b1);
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    repeat (10) tick();
    check("abort_saw_valid", saw_valid, 1'b0);
    check("abort_valid", sig_valid_o, 1'b0);
    check("abort_last", sig_last_o, 1'b0);
    check("abort_req", mem_req_o, 1'b0);
    check("abort_addr", mem_addr_o, 32'd0);
    check("abort_data", sig_data_o, 32'd0);
    check("abort_done", test_done_o, 1'b0);
    check("abort_pass", test_pass_o, 1'b0);
    check("abort_err", sig_err_o, 1'b0);
    check("abort_timeout", timeout_o, 1'b0);
    check("abort_code", test_code_o, 31'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
